// File: rtl/encoder83_scan.sv
// -----------------------------------------------------------------------------
// encoder83_scan
//
// Sequential 8-to-3 encoder (inverse of a 3-8 decoder). Eight raw key/strobe
// lines are synchronised, debounced, and priority-encoded into a 3-bit index.
// Each accepted press produces exactly one event, and the next event needs a
// debounced release first, so a key held down never auto-repeats.
//
// Handshake: o_valid/o_sel/o_multi form one event. Once o_valid rises, all
// three outputs hold steady until a rising edge samples i_ready high with
// o_valid high. That edge transfers the event and drops o_valid. i_ready has
// no effect while o_valid is low.
//
// Parameters:
//   DEBOUNCE_CYC  stable cycles needed to accept a press and a release (1..255)
//   CNT_W         debounce counter width, 2**CNT_W > DEBOUNCE_CYC
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset
//   i_y      raw line inputs, asynchronous to i_clk
//   i_opt    line polarity: 0 = active-low, 1 = active-high (quasi-static)
//   i_ready  consumer accepts the event
//   o_sel    index of the lowest-numbered active line in the accepted vector
//   o_multi  two or more lines were active in the accepted vector
//   o_valid  event present
// -----------------------------------------------------------------------------
module encoder83_scan #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int CNT_W        = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_y,
  input  logic       i_opt,
  input  logic       i_ready,
  output logic [2:0] o_sel,
  output logic       o_multi,
  output logic       o_valid
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESENT  = 2'd2;
  localparam logic [1:0] ST_HOLD     = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [7:0]       r_s1;
  logic [7:0]       r_s2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_cand;
  logic [2:0]       r_sel;
  logic             r_multi;
  logic             r_valid;

  logic [7:0]       w_v;
  logic             w_cnt_done;
  logic [2:0]       w_enc_sel;
  logic             w_enc_multi;

  // A 1 in w_v always means "line active", whatever the polarity.
  assign w_v        = i_opt ? r_s2 : ~r_s2;
  assign w_cnt_done = (r_cnt == CNT_LAST);

  // Bit 0 has the highest priority. The loop runs from the top bit down so
  // that the last match it records is the lowest set bit.
  always_comb begin
    w_enc_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_cand[i]) w_enc_sel = 3'(i);
    end
  end

  // Clearing the lowest set bit leaves a nonzero value only if two or more
  // bits were set.
  assign w_enc_multi = |(r_cand & (r_cand - 8'd1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // Loading the inactive level makes the first normalised vector after
      // reset read as "no line active".
      r_s1    <= {8{~i_opt}};
      r_s2    <= {8{~i_opt}};
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_sel   <= 3'd0;
      r_multi <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_s1 <= i_y;
      r_s2 <= r_s1;

      case (r_state)
        ST_IDLE: begin
          if (w_v != 8'd0) begin
            r_state <= ST_DEBOUNCE;
            r_cand  <= w_v;
            r_cnt   <= '0;
          end
        end

        ST_DEBOUNCE: begin
          if (w_v == 8'd0) begin
            r_state <= ST_IDLE;
          end else if (w_v != r_cand) begin
            // A different key set restarts the count with the new vector.
            r_cand <= w_v;
            r_cnt  <= '0;
          end else if (w_cnt_done) begin
            r_state <= ST_PRESENT;
            r_sel   <= w_enc_sel;
            r_multi <= w_enc_multi;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_PRESENT: begin
          // The event is frozen here. Input changes are ignored until the
          // consumer takes it.
          if (i_ready) begin
            r_state <= ST_HOLD;
            r_valid <= 1'b0;
            r_cnt   <= '0;
          end
        end

        ST_HOLD: begin
          // Any activity restarts the release count. This is what stops a
          // held key from producing repeat events.
          if (w_v != 8'd0) begin
            r_cnt <= '0;
          end else if (w_cnt_done) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_sel   = r_sel;
  assign o_multi = r_multi;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_encoder83_scan.sv
// -----------------------------------------------------------------------------
// tb_encoder83_scan
//
// Bench for encoder83_scan. The reference model tracks the normalised line
// vector as seen two edges late, and keeps run lengths of stable vectors:
//   - a press is accepted once the same nonzero vector has been seen on
//     DEBOUNCE_CYC+1 consecutive edges;
//   - after a handshake, the model re-arms only after DEBOUNCE_CYC consecutive
//     all-released edges.
// Each accepted press is pushed to exp_q with its cycle stamp. The monitor
// pops an entry whenever the DUT raises o_valid, and checks the held outputs
// on every cycle the event stays presented.
// -----------------------------------------------------------------------------
module tb_encoder83_scan;

  localparam int D = 16;

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] y;
  logic       opt;
  logic       ready;
  logic [2:0] o_sel;
  logic       o_multi;
  logic       o_valid;

  always #5 clk = ~clk;

  encoder83_scan #(.DEBOUNCE_CYC(D), .CNT_W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_y     (y),
    .i_opt   (opt),
    .i_ready (ready),
    .o_sel   (o_sel),
    .o_multi (o_multi),
    .o_valid (o_valid)
  );

  // ---------------------------------------------------------------- scoreboard
  int          n_checks   = 0;
  int          n_fail     = 0;
  int          events_exp = 0;
  int          events_seen = 0;
  int unsigned cyc        = 0;
  logic [19:0] exp_q[$];          // {cycle stamp[15:0], multi, sel[2:0]}

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] ref_encode(input logic [7:0] v);
    int   idx;
    logic mult;
    idx  = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = i;
        break;
      end
    end
    mult = ($countones(v) >= 2);
    return {mult, 3'(idx)};
  endfunction

  // ---------------------------------------------------------------- reference model
  logic [7:0] m_y1 = 8'hFF;
  logic [7:0] m_y2 = 8'hFF;
  logic [7:0] m_last = 8'h00;
  int         m_mode = 0;         // 0 armed, 1 event pending, 2 awaiting release
  int         m_run  = 0;
  int         m_rel  = 0;
  logic       m_pending = 1'b0;

  task automatic model_step();
    logic [7:0] v;
    logic [3:0] e;
    cyc++;
    if (!rst_n) begin
      m_y1      = {8{~opt}};
      m_y2      = {8{~opt}};
      m_mode    = 0;
      m_run     = 0;
      m_pending = 1'b0;
    end else begin
      v    = opt ? m_y2 : ~m_y2;
      m_y2 = m_y1;
      m_y1 = y;
      case (m_mode)
        0: begin
          if (v == 8'd0) m_run = 0;
          else if (m_run > 0 && v == m_last) m_run++;
          else begin
            m_run  = 1;
            m_last = v;
          end
          if (m_run == D + 1) begin
            e = ref_encode(m_last);
            exp_q.push_back({cyc[15:0], e});
            events_exp++;
            m_pending = 1'b1;
            m_mode    = 1;
          end
        end
        1: begin
          if (ready) begin
            m_pending = 1'b0;
            m_mode    = 2;
            m_rel     = 0;
          end
        end
        default: begin
          if (v != 8'd0) m_rel = 0;
          else m_rel++;
          if (m_rel == D) begin
            m_mode = 0;
            m_run  = 0;
          end
        end
      endcase
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------------------------------------------------------- monitor
  logic        mon_prev_valid = 1'b0;
  logic [3:0]  mon_held = 4'd0;

  initial begin
    logic [19:0] e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("valid_level", {31'd0, o_valid}, {31'd0, m_pending});
      if (o_valid && !mon_prev_valid) begin
        events_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got sel %0d multi %0d expected no event (cycle %0d)",
                   o_sel, o_multi, cyc);
        end else begin
          e = exp_q.pop_front();
          check("event_sel",   {29'd0, o_sel},   {29'd0, e[2:0]});
          check("event_multi", {31'd0, o_multi}, {31'd0, e[3]});
          check("event_cycle", {16'd0, cyc[15:0]}, {16'd0, e[19:4]});
          mon_held = e[3:0];
        end
      end else if (o_valid) begin
        check("held_outputs", {28'd0, o_multi, o_sel}, {28'd0, mon_held});
      end
      mon_prev_valid = o_valid;
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold_y(input logic [7:0] v, input int n);
    y = v;
    step(n);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k;
    k = 0;
    while (!o_valid && k < budget) begin
      step(1);
      k++;
    end
    check(name, {31'd0, o_valid}, 32'd1);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [7:0] pats [6];

  initial begin
    int lat;
    pats = '{8'hFF, 8'hFE, 8'hF7, 8'hDB, 8'h7F, 8'h00};

    rst_n = 1'b0;
    opt   = 1'b0;
    y     = 8'hFF;
    ready = 1'b1;
    step(3);
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_sel",   {29'd0, o_sel},   32'd0);
    check("reset_multi", {31'd0, o_multi}, 32'd0);
    rst_n = 1'b1;
    step(5);

    // Single key, active-low; latency measured from the first sampling edge.
    y   = 8'hF7;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (o_valid) begin
        lat = k;
        break;
      end
    end
    check("press_latency", lat, D + 3);
    check("press_sel", {29'd0, o_sel}, 32'd3);
    step(1);
    check("one_cycle_pulse", {31'd0, o_valid}, 32'd0);
    step(200);                        // held key: no repeat
    hold_y(8'hFF, 20);

    // Two keys: lowest index wins, multi flagged.
    hold_y(8'hDB, 25);
    hold_y(8'hFF, 20);

    // Bounce shorter than the debounce window never produces an event.
    for (int k = 0; k < 10; k++) begin
      hold_y(8'hFF, 3);
      hold_y(8'hFE, 3);
    end
    hold_y(8'hFE, 25);
    hold_y(8'hFF, 20);

    // Back-pressure: outputs frozen while the consumer stalls.
    ready = 1'b0;
    y     = 8'hFD;
    wait_valid(40, "stall_valid_rise");
    y = 8'h7F;
    step(50);
    check("stall_valid_held", {31'd0, o_valid}, 32'd1);
    check("stall_sel_held",   {29'd0, o_sel},   32'd1);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("handshake_drop", {31'd0, o_valid}, 32'd0);
    step(10);                         // 7F still pressed: release not yet seen
    hold_y(8'hFF, 20);
    ready = 1'b1;
    hold_y(8'h7F, 25);
    hold_y(8'hFF, 20);

    // Active-high polarity, selected under reset.
    rst_n = 1'b0;
    opt   = 1'b1;
    y     = 8'h00;
    step(2);
    rst_n = 1'b1;
    step(3);
    hold_y(8'h80, 25);
    hold_y(8'h00, 40);

    // Reset while an event is presented drops it.
    ready = 1'b0;
    y     = 8'h01;
    wait_valid(40, "pre_reset_valid");
    rst_n = 1'b0;
    y     = 8'h00;
    step(1);
    check("reset_drops_event", {31'd0, o_valid}, 32'd0);
    rst_n = 1'b1;
    step(5);
    ready = 1'b1;
    hold_y(8'h04, 25);
    hold_y(8'h00, 20);

    // Randomised phase, active-low.
    rst_n = 1'b0;
    opt   = 1'b0;
    y     = 8'hFF;
    step(2);
    rst_n = 1'b1;
    step(2);
    for (int k = 0; k < 150; k++) begin
      ready = ($urandom_range(0, 3) != 0);
      hold_y(pats[$urandom_range(0, 5)], $urandom_range(1, 24));
    end
    ready = 1'b1;
    hold_y(8'hFF, 60);

    check("queue_drained", exp_q.size(), 32'd0);
    check("event_count", events_seen, events_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
